// File: rtl/cond_inv_pkg.sv
// Shared types and default sizing for the conditional-invert pipeline.
// mode_t selects the operation applied to each accepted word.
package cond_inv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_MASK   = 2'b01,
        MODE_GLOBAL = 2'b10,
        MODE_SUB    = 2'b11
    } mode_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 2;

endpackage : cond_inv_pkg

// File: rtl/cond_inv_pipe_if.sv
// Valid/ready bus of the conditional-invert pipeline: upstream word plus
// downstream result. slave is the pipeline's view, master the driver's view.
interface cond_inv_pipe_if
    import cond_inv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    mode_t            mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             sub_cin;

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, out, sub_cin
    );

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, out, sub_cin
    );

endinterface : cond_inv_pipe_if

// File: rtl/cond_inv_stage.sv
// One valid/data register slice of an elastic pipeline. It loads whenever it
// is empty or its current word leaves this cycle, so bubbles collapse.
module cond_inv_stage #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         up_vld_i,
    input  logic [W-1:0] up_data_i,
    output logic         up_rdy_o,
    output logic         dn_vld_o,
    output logic [W-1:0] dn_data_o,
    input  logic         dn_rdy_i
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    assign up_rdy_o  = !vld_q || dn_rdy_i;
    assign dn_vld_o  = vld_q;
    assign dn_data_o = data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (up_rdy_o) begin
            vld_d = up_vld_i;
            // Data only moves with a real word, so a held result never glitches.
            if (up_vld_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

endmodule : cond_inv_stage

// File: rtl/cond_inv_pipe.sv
// Conditional inverter feeding a downstream adder: computes pass/mask/global
// invert/subtract-prep on each word, then carries {sub_cin, out} through STAGES slices.
module cond_inv_pipe
    import cond_inv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic              clkpos,
    input  logic              clkneg,
    input  logic              rst_n,
    input  logic              vdd,
    input  logic              vss,
    cond_inv_pipe_if.slave    bus
);

    localparam int W = WIDTH + 1;

    // Pins kept only so the netlist footprint matches; they carry no function.
    logic unused_pins;
    assign unused_pins = ^{clkneg, vdd, vss};

    function automatic logic [WIDTH:0] cond_op(
        input mode_t            m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (m)
            MODE_PASS:   return {1'b0, a};
            MODE_MASK:   return {1'b0, a ^ b};
            MODE_GLOBAL: return {1'b0, (b[0] ? ~a : a)};
            MODE_SUB:    return {1'b1, ~a};
            default:     return {1'b0, a};
        endcase
    endfunction

    logic [STAGES:0]        vld_s;
    logic [STAGES:0]        rdy_s;
    logic [STAGES:0][W-1:0] data_s;

    assign vld_s[0]  = bus.in_valid;
    assign data_s[0] = cond_op(bus.mode, bus.a, bus.b);
    assign rdy_s[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cond_inv_stage #(.W(W)) u_stage (
            .clk_i     (clkpos),
            .rst_n_i   (rst_n),
            .up_vld_i  (vld_s[k]),
            .up_data_i (data_s[k]),
            .up_rdy_o  (rdy_s[k]),
            .dn_vld_o  (vld_s[k+1]),
            .dn_data_o (data_s[k+1]),
            .dn_rdy_i  (rdy_s[k+1])
        );
    end

    assign bus.in_ready  = rdy_s[0];
    assign bus.out_valid = vld_s[STAGES];
    assign bus.out       = data_s[STAGES][WIDTH-1:0];
    assign bus.sub_cin   = data_s[STAGES][WIDTH];

endmodule : cond_inv_pipe

// File: tb/tb_cond_inv_pipe.sv
// Directed bench for cond_inv_pipe (WIDTH=16, STAGES=2): streamed vector
// table plus stall and mid-run reset sequences.
module tb_cond_inv_pipe;
    import cond_inv_pkg::*;

    localparam int NV = 12;

    logic clkpos = 1'b0;
    logic clkneg;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;
    logic vdd    = 1'b1;
    logic vss    = 1'b0;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        mode_t       mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic        exp_cin;
    } vec_t;

    vec_t tbl [NV];

    cond_inv_pipe_if #(.WIDTH(16)) bus ();

    cond_inv_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clkpos (clkpos),
        .clkneg (clkneg),
        .rst_n  (rst_n),
        .vdd    (vdd),
        .vss    (vss),
        .bus    (bus)
    );

    always #5 if (clk_en) clkpos = ~clkpos;
    assign clkneg = ~clkpos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [15:0] eo, input logic ec);
        check({name, "_vld"}, 32'(bus.out_valid), 32'd1);
        check({name, "_out"}, 32'(bus.out), 32'(eo));
        check({name, "_cin"}, 32'(bus.sub_cin), 32'(ec));
    endtask

    task automatic drive(input logic v, input mode_t m, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = v;
        bus.mode     = m;
        bus.a        = a;
        bus.b        = b;
    endtask

    initial begin
        tbl[0]  = '{MODE_MASK,   16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0};
        tbl[1]  = '{MODE_GLOBAL, 16'hA5A5, 16'h0001, 16'h5A5A, 1'b0};
        tbl[2]  = '{MODE_GLOBAL, 16'hA5A5, 16'h0000, 16'hA5A5, 1'b0};
        tbl[3]  = '{MODE_SUB,    16'h1234, 16'h0000, 16'hEDCB, 1'b1};
        tbl[4]  = '{MODE_PASS,   16'hBEEF, 16'hFFFF, 16'hBEEF, 1'b0};
        tbl[5]  = '{MODE_MASK,   16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
        tbl[6]  = '{MODE_GLOBAL, 16'h1357, 16'hFFFE, 16'h1357, 1'b0};
        tbl[7]  = '{MODE_SUB,    16'h0000, 16'h0000, 16'hFFFF, 1'b1};
        tbl[8]  = '{MODE_MASK,   16'h8001, 16'h7FFF, 16'hFFFE, 1'b0};
        tbl[9]  = '{MODE_GLOBAL, 16'h0F0F, 16'h0003, 16'hF0F0, 1'b0};
        tbl[10] = '{MODE_SUB,    16'hFFFF, 16'h5555, 16'h0000, 1'b1};
        tbl[11] = '{MODE_PASS,   16'h0000, 16'h1234, 16'h0000, 1'b0};

        drive(1'b1, MODE_SUB, 16'hFFFF, 16'hFFFF);
        bus.out_ready = 1'b1;

        // Reset with the clock idle
        #2;
        check("rst_vld", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.out), 32'h0000);
        check("rst_cin", 32'(bus.sub_cin), 32'd0);
        drive(1'b0, MODE_PASS, 16'h0000, 16'h0000);
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        clk_en = 1'b1;

        // Streamed table: word c presented in cycle c must appear in cycle c+2
        for (int c = 0; c < NV + 3; c++) begin
            @(negedge clkpos);
            if (c >= 2 && c < NV + 2) begin
                check_out($sformatf("tbl%0d", c - 2), tbl[c-2].exp_out, tbl[c-2].exp_cin);
            end else begin
                check($sformatf("tbl_idle%0d", c), 32'(bus.out_valid), 32'd0);
            end
            if (c < NV) drive(1'b1, tbl[c].mode, tbl[c].a, tbl[c].b);
            else        drive(1'b0, MODE_PASS, 16'h0000, 16'h0000);
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("tbl_rdy%0d", c), 32'(bus.in_ready), 32'd1);
        end

        // Stall: fill with 1,2 while downstream blocks, then release
        @(negedge clkpos);
        check("st0_vld", 32'(bus.out_valid), 32'd0);
        drive(1'b1, MODE_PASS, 16'h0001, 16'hFFFF);
        bus.out_ready = 1'b0;
        #1 check("st0_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clkpos);
        check("st1_vld", 32'(bus.out_valid), 32'd0);
        drive(1'b1, MODE_PASS, 16'h0002, 16'hFFFF);
        #1 check("st1_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clkpos);
        check_out("st2", 16'h0001, 1'b0);
        drive(1'b1, MODE_PASS, 16'h0003, 16'hFFFF);
        #1 check("st2_rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clkpos);
        check_out("st3_hold", 16'h0001, 1'b0);
        #1 check("st3_rdy", 32'(bus.in_ready), 32'd0);
        @(negedge clkpos);
        check_out("st4", 16'h0001, 1'b0);
        bus.out_ready = 1'b1;
        #1 check("st4_rdy_full", 32'(bus.in_ready), 32'd1);
        @(negedge clkpos);
        check_out("st5", 16'h0002, 1'b0);
        drive(1'b0, MODE_PASS, 16'h0000, 16'h0000);
        @(negedge clkpos);
        check_out("st6", 16'h0003, 1'b0);
        @(negedge clkpos);
        check("st7_vld", 32'(bus.out_valid), 32'd0);

        // Mid-run reset with two words in flight
        drive(1'b1, MODE_SUB, 16'hAAAA, 16'h0000);
        @(negedge clkpos);
        drive(1'b1, MODE_SUB, 16'h5555, 16'h0000);
        @(negedge clkpos);
        check_out("mr_pre", 16'h5555, 1'b1);
        drive(1'b0, MODE_PASS, 16'h0000, 16'h0000);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_vld", 32'(bus.out_valid), 32'd0);
        check("mr_out", 32'(bus.out), 32'h0000);
        check("mr_cin", 32'(bus.sub_cin), 32'd0);
        #1 rst_n = 1'b1;
        #1 check("mr_rdy", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clkpos);
            check($sformatf("mr_after%0d", c), 32'(bus.out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_cond_inv_pipe
